pe_message_passer_q: RTL and testbench
======================================

PE_MESSAGE_PASSER_Q -- requirements
Module: pe_message_passer_q

Interface
REQ-001 SHALL have parameter PRECISION, default 8, meaning operand/neighbour-port width.
REQ-002 SHALL have parameter OUTPUT_PRECISION, default 32, meaning accumulator width (at least 2*PRECISION).
REQ-003 SHALL have parameter COMMAND_WIDTH, default 4, meaning opcode width.
REQ-004 SHALL have parameter CMD_DEPTH, default 4, meaning command-queue entries (power of two, at least 2).
REQ-005 SHALL use one clock; reset is synchronous and active-high. Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue can accept
- command  in  COMMAND_WIDTH  opcode
- a_overwrite, b_overwrite  in  PRECISION  load operands
- s_out_overwrite  in  OUTPUT_PRECISION  load operand
- isu, isd, isl, isr  in  PRECISION  neighbour inputs
- osu, osd, osl, osr  out  PRECISION  neighbour outputs
- A, B  out  PRECISION  operand registers
- s_out  out  OUTPUT_PRECISION  accumulator
- done  out  1  one-cycle completion pulse
- busy  out  1  FSM not IDLE or queue non-empty
- overflow  out  1  sticky accumulator overflow

Function
REQ-006 SHALL enqueue {command, a_overwrite, b_overwrite, s_out_overwrite} when cmd_valid && cmd_ready; cmd_ready = queue not full.
REQ-007 SHALL sample isu/isd/isl/isr during EXEC, not at enqueue.
REQ-008 SHALL implement FSM IDLE -> EXEC -> (MAC2 if opcode 0) -> DONE -> IDLE; IDLE pops the queue head when non-empty, otherwise stays.
REQ-009 SHALL assert done exactly one cycle in DONE for every executed command, including NOPs.
REQ-010 SHALL decode: 0 MAC; 1 A,osu<=isu; 2 A,osd<=isd; 3 A,osl<=isl; 4 A,osr<=isr; 5 A<=a_overwrite; 6 B<=b_overwrite; 7 s_out<=s_out_overwrite, clear overflow; 8 clear A,B,s_out,all os*,overflow; 9 B,osl<=isl; 10 B,osu<=isu; 11-15 NOP.
REQ-011 SHALL, for MAC, register unsigned A*B (2*PRECISION bits) in EXEC and add it zero-extended to s_out in MAC2.
REQ-012 SHALL wrap the sum modulo 2^OUTPUT_PRECISION and set overflow on carry-out (default build).
REQ-013 SHALL give latency pop-to-done of 3 cycles for non-MAC, 4 for MAC.
REQ-014 SHALL, on push into a queue being popped in the same cycle, accept both; full queue refuses push regardless of same-cycle pop.
REQ-015 SHALL preserve queue order; pointers wrap at CMD_DEPTH.

Reset
REQ-016 SHALL on RST clear A, B, s_out, os*, overflow, done to 0, empty the queue, force IDLE, cmd_ready=1, busy=0.
REQ-017 SHALL discard an in-flight command (including mid-MAC) on RST without pulsing done.

Configuration
REQ-018 SHALL, with MP_SATURATE_EN defined, clamp an overflowing MAC sum to all-ones and still set overflow; without it, wrap per REQ-012.

Verification
REQ-019 Push 5 (a_ow=0x3D), 6 (b_ow=0x71), 0, 0 -> s_out=6893 after first done, 13786 after second; overflow=0.
REQ-020 isu=0x69, opcode 1 -> A=0x69, osu=0x69; isl=0x86, opcode 9 -> B=0x86, osl=0x86, A unchanged.
REQ-021 A=0x3D, B=0x71, opcode 7 with 0xFFFFFFF0, then 0 -> s_out=0x00001ADD, overflow=1 (wrap); 0xFFFFFFFF with MP_SATURATE_EN.
REQ-022 Hold FSM busy, push CMD_DEPTH+1 commands -> cmd_ready=0 after CMD_DEPTH, extra refused, all accepted execute in order with one done each.
REQ-023 Assert RST during MAC2 -> next cycle all outputs 0, queue empty, no done pulse.
REQ-024 Opcode 13 -> done pulses, no register changes; opcode 8 after loads -> A=B=s_out=0, overflow=0.

Source files
------------

// File: rtl/pe_message_passer_q.sv
// ---------------------------------------------------------------------------
// pe_message_passer_q
// Processing element with a small command queue. Each queued command is
// executed by the FSM IDLE -> EXEC -> (MAC2 for MAC) -> DONE -> IDLE.
// Depending on the opcode, a command loads an operand, captures a neighbour
// input into an operand and its matching neighbour output, multiply-
// accumulates A*B into s_out, or clears the datapath.
//
// Configuration:
//   MP_SATURATE_EN  when defined, an overflowing MAC sum clamps s_out to
//                   all-ones. When undefined (default), the sum wraps.
//                   overflow is set on carry-out in both builds.
//
// Ports:
//   CLK                  clock
//   RST                  synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (cmd_ready = queue not full)
//   command              opcode
//   a_/b_/s_out_overwrite  load operands, captured into the queue on push
//   isu/isd/isl/isr      neighbour inputs, sampled during EXEC
//   osu/osd/osl/osr      neighbour outputs (registered)
//   A, B                 operand registers
//   s_out                accumulator
//   done                 one-cycle pulse per executed command
//   busy                 FSM not idle or queue not empty
//   overflow             sticky accumulator overflow
// ---------------------------------------------------------------------------
module pe_message_passer_q #(
    parameter int unsigned PRECISION        = 8,
    parameter int unsigned OUTPUT_PRECISION = 32,
    parameter int unsigned COMMAND_WIDTH    = 4,
    parameter int unsigned CMD_DEPTH        = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [COMMAND_WIDTH-1:0]    command,
    input  logic [PRECISION-1:0]        a_overwrite,
    input  logic [PRECISION-1:0]        b_overwrite,
    input  logic [OUTPUT_PRECISION-1:0] s_out_overwrite,
    input  logic [PRECISION-1:0]        isu,
    input  logic [PRECISION-1:0]        isd,
    input  logic [PRECISION-1:0]        isl,
    input  logic [PRECISION-1:0]        isr,
    output logic [PRECISION-1:0]        osu,
    output logic [PRECISION-1:0]        osd,
    output logic [PRECISION-1:0]        osl,
    output logic [PRECISION-1:0]        osr,
    output logic [PRECISION-1:0]        A,
    output logic [PRECISION-1:0]        B,
    output logic [OUTPUT_PRECISION-1:0] s_out,
    output logic                        done,
    output logic                        busy,
    output logic                        overflow
);

    localparam int unsigned PROD_W = 2 * PRECISION;
    localparam int unsigned SUM_W  = OUTPUT_PRECISION + 1;
    localparam int unsigned PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [COMMAND_WIDTH-1:0] OP_MAC   = COMMAND_WIDTH'(0);
    localparam logic [COMMAND_WIDTH-1:0] OP_A_U   = COMMAND_WIDTH'(1);
    localparam logic [COMMAND_WIDTH-1:0] OP_A_D   = COMMAND_WIDTH'(2);
    localparam logic [COMMAND_WIDTH-1:0] OP_A_L   = COMMAND_WIDTH'(3);
    localparam logic [COMMAND_WIDTH-1:0] OP_A_R   = COMMAND_WIDTH'(4);
    localparam logic [COMMAND_WIDTH-1:0] OP_LD_A  = COMMAND_WIDTH'(5);
    localparam logic [COMMAND_WIDTH-1:0] OP_LD_B  = COMMAND_WIDTH'(6);
    localparam logic [COMMAND_WIDTH-1:0] OP_LD_S  = COMMAND_WIDTH'(7);
    localparam logic [COMMAND_WIDTH-1:0] OP_CLR   = COMMAND_WIDTH'(8);
    localparam logic [COMMAND_WIDTH-1:0] OP_B_L   = COMMAND_WIDTH'(9);
    localparam logic [COMMAND_WIDTH-1:0] OP_B_U   = COMMAND_WIDTH'(10);

    typedef struct packed {
        logic [COMMAND_WIDTH-1:0]    cmd;
        logic [PRECISION-1:0]        a_ow;
        logic [PRECISION-1:0]        b_ow;
        logic [OUTPUT_PRECISION-1:0] s_ow;
    } cmd_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MAC2,
        ST_DONE
    } fsm_state_t;

    fsm_state_t          state;
    cmd_entry_t          cur;
    logic [PROD_W-1:0]   product_q;
    logic [SUM_W-1:0]    mac_sum;

    cmd_entry_t          fifo_mem [CMD_DEPTH];
    cmd_entry_t          entry_in;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                q_full;
    logic                q_empty;
    logic                push;
    logic                pop;

    // Queue status and handshake decode; full refuses even with a same-cycle pop.
    assign q_full    = (count == CNT_W'(CMD_DEPTH));
    assign q_empty   = (count == '0);
    assign cmd_ready = !q_full;
    assign push      = cmd_valid && !q_full;
    assign pop       = (state == ST_IDLE) && !q_empty;
    assign busy      = (state != ST_IDLE) || !q_empty;

    assign entry_in = '{cmd:  command,
                        a_ow: a_overwrite,
                        b_ow: b_overwrite,
                        s_ow: s_out_overwrite};

    // Accumulate with one extra bit to expose the carry-out.
    assign mac_sum = {1'b0, s_out} + SUM_W'(product_q);

    // Queue pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= entry_in;
        end
    end

    // Command FSM and datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            cur       <= '0;
            product_q <= '0;
            A         <= '0;
            B         <= '0;
            s_out     <= '0;
            osu       <= '0;
            osd       <= '0;
            osl       <= '0;
            osr       <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!q_empty) begin
                        cur   <= fifo_mem[rd_ptr];
                        state <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    // Non-MAC commands finish here; MAC overrides below.
                    state <= ST_DONE;
                    done  <= 1'b1;
                    case (cur.cmd)
                        OP_MAC: begin
                            product_q <= PROD_W'(A) * PROD_W'(B);
                            state     <= ST_MAC2;
                            done      <= 1'b0;
                        end
                        OP_A_U: begin
                            A   <= isu;
                            osu <= isu;
                        end
                        OP_A_D: begin
                            A   <= isd;
                            osd <= isd;
                        end
                        OP_A_L: begin
                            A   <= isl;
                            osl <= isl;
                        end
                        OP_A_R: begin
                            A   <= isr;
                            osr <= isr;
                        end
                        OP_LD_A: begin
                            A <= cur.a_ow;
                        end
                        OP_LD_B: begin
                            B <= cur.b_ow;
                        end
                        OP_LD_S: begin
                            s_out    <= cur.s_ow;
                            overflow <= 1'b0;
                        end
                        OP_CLR: begin
                            A        <= '0;
                            B        <= '0;
                            s_out    <= '0;
                            osu      <= '0;
                            osd      <= '0;
                            osl      <= '0;
                            osr      <= '0;
                            overflow <= 1'b0;
                        end
                        OP_B_L: begin
                            B   <= isl;
                            osl <= isl;
                        end
                        OP_B_U: begin
                            B   <= isu;
                            osu <= isu;
                        end
                        default: begin
                            // Remaining opcodes are NOPs: only done pulses.
                        end
                    endcase
                end

                ST_MAC2: begin
`ifdef MP_SATURATE_EN
                    if (mac_sum[OUTPUT_PRECISION]) begin
                        s_out <= '1;
                    end else begin
                        s_out <= mac_sum[OUTPUT_PRECISION-1:0];
                    end
`else
                    s_out <= mac_sum[OUTPUT_PRECISION-1:0];
`endif
                    overflow <= overflow | mac_sum[OUTPUT_PRECISION];
                    state    <= ST_DONE;
                    done     <= 1'b1;
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_message_passer_q.sv
// ---------------------------------------------------------------------------
// tb_pe_message_passer_q
// Table of {command, operands, neighbour inputs, expected state} records
// applied one at a time, plus hand-written sequences for latency, late
// neighbour sampling, queue fill/refusal and reset during MAC2. Expected
// states are queued when a command is accepted and compared on each done.
// ---------------------------------------------------------------------------
module tb_pe_message_passer_q;

    localparam int unsigned P     = 8;
    localparam int unsigned OP    = 32;
    localparam int unsigned CW    = 4;
    localparam int unsigned DEPTH = 4;

`ifdef MP_SATURATE_EN
    localparam logic [31:0] WRAP_EXP = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] WRAP_EXP = 32'h0000_1ADD;
`endif

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [31:0] s;
        logic [7:0]  osu;
        logic [7:0]  osd;
        logic [7:0]  osl;
        logic [7:0]  osr;
        logic        ovf;
    } obs_t;

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a_ow;
        logic [7:0]  b_ow;
        logic [31:0] s_ow;
        logic [7:0]  iu;
        logic [7:0]  id;
        logic [7:0]  il;
        logic [7:0]  ir;
        obs_t        exp;
    } vec_t;

    logic           sys_clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [CW-1:0]  command;
    logic [P-1:0]   a_overwrite, b_overwrite;
    logic [OP-1:0]  s_out_overwrite;
    logic [P-1:0]   isu, isd, isl, isr;
    logic [P-1:0]   osu, osd, osl, osr;
    logic [P-1:0]   A, B;
    logic [OP-1:0]  s_out;
    logic           done, busy, overflow;

    obs_t           sb[$];
    obs_t           drv_exp;
    obs_t           model;
    int unsigned    n_vec = 0;
    int unsigned    n_err = 0;
    vec_t           tbl [26];

    always #5 sys_clk = ~sys_clk;

    pe_message_passer_q #(
        .PRECISION        (P),
        .OUTPUT_PRECISION (OP),
        .COMMAND_WIDTH    (CW),
        .CMD_DEPTH        (DEPTH)
    ) dut (
        .CLK             (sys_clk),
        .RST             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .command         (command),
        .a_overwrite     (a_overwrite),
        .b_overwrite     (b_overwrite),
        .s_out_overwrite (s_out_overwrite),
        .isu             (isu),
        .isd             (isd),
        .isl             (isl),
        .isr             (isr),
        .osu             (osu),
        .osd             (osd),
        .osl             (osl),
        .osr             (osr),
        .A               (A),
        .B               (B),
        .s_out           (s_out),
        .done            (done),
        .busy            (busy),
        .overflow        (overflow)
    );

    function automatic obs_t st(input logic [7:0] a, input logic [7:0] b,
                                input logic [31:0] s, input logic [7:0] u,
                                input logic [7:0] d, input logic [7:0] l,
                                input logic [7:0] r, input logic ov);
        obs_t o;
        o.a = a; o.b = b; o.s = s; o.osu = u; o.osd = d; o.osl = l; o.osr = r; o.ovf = ov;
        return o;
    endfunction

    function automatic vec_t mkv(input logic [3:0] op, input logic [7:0] aow,
                                 input logic [7:0] bow, input logic [31:0] sow,
                                 input logic [7:0] iu, input logic [7:0] id,
                                 input logic [7:0] il, input logic [7:0] ir,
                                 input obs_t e);
        vec_t v;
        v.op = op; v.a_ow = aow; v.b_ow = bow; v.s_ow = sow;
        v.iu = iu; v.id = id; v.il = il; v.ir = ir; v.exp = e;
        return v;
    endfunction

    function automatic obs_t dut_state();
        return st(A, B, s_out, osu, osd, osl, osr, overflow);
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got A=%h B=%h s_out=%h osu=%h osd=%h osl=%h osr=%h ovf=%b ; want A=%h B=%h s_out=%h osu=%h osd=%h osl=%h osr=%h ovf=%b",
                     name, got.a, got.b, got.s, got.osu, got.osd, got.osl, got.osr, got.ovf,
                     want.a, want.b, want.s, want.osu, want.osd, want.osl, want.osr, want.ovf);
        end
    endtask

    task automatic check_int(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Scoreboard push: a command is accepted on a clock edge with valid && ready.
    always @(posedge sys_clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            sb.push_back(drv_exp);
        end
    end

    // Scoreboard pop: every done pulse must match the oldest accepted command.
    always @(negedge sys_clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 with no command pending, want done=0");
            end else begin
                check_obs("done_state", dut_state(), sb.pop_front());
            end
        end
    end

    task automatic push(input vec_t v);
        @(negedge sys_clk);
        command         = v.op;
        a_overwrite     = v.a_ow;
        b_overwrite     = v.b_ow;
        s_out_overwrite = v.s_ow;
        isu = v.iu; isd = v.id; isl = v.il; isr = v.ir;
        drv_exp   = v.exp;
        model     = v.exp;
        cmd_valid = 1'b1;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            cyc++;
            if (done) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL done_timeout: got no done after %0d cycles, want a done pulse", cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    cyc;
        int    acc;
        bit    saw_full;
        bit    released;
        vec_t  v;

        // Junk in unused fields catches decode that reads the wrong source.
        tbl[0]  = mkv(4'd8,  8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'h00, 8'h00, 32'h0,         8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        tbl[1]  = mkv(4'd5,  8'h3D, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'h3D, 8'h00, 32'h0,         8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        tbl[2]  = mkv(4'd6,  8'hC1, 8'h71, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'h3D, 8'h71, 32'h0,         8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        tbl[3]  = mkv(4'd0,  8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'h3D, 8'h71, 32'd6893,      8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        tbl[4]  = mkv(4'd0,  8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'h3D, 8'h71, 32'd13786,     8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        tbl[5]  = mkv(4'd1,  8'hC1, 8'hC2, 32'hDEADBEEF, 8'h69, 8'hE2, 8'hE3, 8'hE4, st(8'h69, 8'h71, 32'd13786,     8'h69, 8'h00, 8'h00, 8'h00, 1'b0));
        tbl[6]  = mkv(4'd9,  8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'h86, 8'hE4, st(8'h69, 8'h86, 32'd13786,     8'h69, 8'h00, 8'h86, 8'h00, 1'b0));
        tbl[7]  = mkv(4'd2,  8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'h12, 8'hE3, 8'hE4, st(8'h12, 8'h86, 32'd13786,     8'h69, 8'h12, 8'h86, 8'h00, 1'b0));
        tbl[8]  = mkv(4'd3,  8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'h34, 8'hE4, st(8'h34, 8'h86, 32'd13786,     8'h69, 8'h12, 8'h34, 8'h00, 1'b0));
        tbl[9]  = mkv(4'd4,  8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'h56, st(8'h56, 8'h86, 32'd13786,     8'h69, 8'h12, 8'h34, 8'h56, 1'b0));
        tbl[10] = mkv(4'd13, 8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'h56, 8'h86, 32'd13786,     8'h69, 8'h12, 8'h34, 8'h56, 1'b0));
        tbl[11] = mkv(4'd10, 8'hC1, 8'hC2, 32'hDEADBEEF, 8'hA7, 8'hE2, 8'hE3, 8'hE4, st(8'h56, 8'hA7, 32'd13786,     8'hA7, 8'h12, 8'h34, 8'h56, 1'b0));
        tbl[12] = mkv(4'd5,  8'h3D, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'h3D, 8'hA7, 32'd13786,     8'hA7, 8'h12, 8'h34, 8'h56, 1'b0));
        tbl[13] = mkv(4'd6,  8'hC1, 8'h71, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'h3D, 8'h71, 32'd13786,     8'hA7, 8'h12, 8'h34, 8'h56, 1'b0));
        tbl[14] = mkv(4'd7,  8'hC1, 8'hC2, 32'hFFFFFFF0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'h3D, 8'h71, 32'hFFFFFFF0,  8'hA7, 8'h12, 8'h34, 8'h56, 1'b0));
        tbl[15] = mkv(4'd0,  8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'h3D, 8'h71, WRAP_EXP,       8'hA7, 8'h12, 8'h34, 8'h56, 1'b1));
        tbl[16] = mkv(4'd15, 8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'h3D, 8'h71, WRAP_EXP,       8'hA7, 8'h12, 8'h34, 8'h56, 1'b1));
        tbl[17] = mkv(4'd7,  8'hC1, 8'hC2, 32'h00000010, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'h3D, 8'h71, 32'h00000010,  8'hA7, 8'h12, 8'h34, 8'h56, 1'b0));
        tbl[18] = mkv(4'd0,  8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'h3D, 8'h71, 32'h00001AFD,  8'hA7, 8'h12, 8'h34, 8'h56, 1'b0));
        tbl[19] = mkv(4'd8,  8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'h00, 8'h00, 32'h0,         8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        tbl[20] = mkv(4'd5,  8'hFF, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'hFF, 8'h00, 32'h0,         8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        tbl[21] = mkv(4'd6,  8'hC1, 8'hFF, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'hFF, 8'hFF, 32'h0,         8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        tbl[22] = mkv(4'd0,  8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'hFF, 8'hFF, 32'h0000FE01,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        tbl[23] = mkv(4'd11, 8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'hFF, 8'hFF, 32'h0000FE01,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        tbl[24] = mkv(4'd12, 8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'hFF, 8'hFF, 32'h0000FE01,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        tbl[25] = mkv(4'd14, 8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, st(8'hFF, 8'hFF, 32'h0000FE01,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0));

        rst = 1'b1;
        cmd_valid = 1'b0;
        command = '0; a_overwrite = '0; b_overwrite = '0; s_out_overwrite = '0;
        isu = '0; isd = '0; isl = '0; isr = '0;
        drv_exp = '0;
        model = '0;
        repeat (3) @(negedge sys_clk);
        check_obs("reset_state", dut_state(), '0);
        check_int("reset_done", 32'(done), 32'd0);
        check_int("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check_int("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Table: one command at a time, each compared on its done pulse.
        for (int i = 0; i < 26; i++) begin
            push(tbl[i]);
            wait_done(cyc);
        end

        // Latency from acceptance: non-MAC done two cycles after push returns, MAC three.
        v = mkv(4'd13, 8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, model);
        push(v);
        wait_done(cyc);
        check_int("latency_nop", 32'(cyc), 32'd2);

        v = mkv(4'd0, 8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4,
                st(model.a, model.b, 32'h0001FC02, model.osu, model.osd, model.osl, model.osr, model.ovf));
        push(v);
        wait_done(cyc);
        check_int("latency_mac", 32'(cyc), 32'd3);

        // Neighbour input changes after enqueue but before EXEC; the later value must be used.
        v = mkv(4'd1, 8'hC1, 8'hC2, 32'hDEADBEEF, 8'h11, 8'hE2, 8'hE3, 8'hE4,
                st(8'h22, model.b, model.s, 8'h22, model.osd, model.osl, model.osr, model.ovf));
        push(v);
        isu = 8'h22;
        wait_done(cyc);

        // Fill the queue faster than it drains, then offer one more while full.
        acc = 0;
        saw_full = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge sys_clk);
            if (!cmd_ready) begin
                saw_full = 1'b1;
                break;
            end
            model.a         = 8'(8'h40 + i);
            command         = 4'd5;
            a_overwrite     = model.a;
            drv_exp         = model;
            cmd_valid       = 1'b1;
            acc++;
        end
        check_int("queue_filled", 32'(saw_full), 32'd1);
        check_int("busy_when_full", 32'(busy), 32'd1);
        check_int("accepted_at_least_depth", 32'(acc >= int'(DEPTH)), 32'd1);

        // Refused command held through the pop edge that frees a slot.
        command     = 4'd5;
        a_overwrite = 8'hEE;
        released    = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge sys_clk);
            if (cmd_ready) begin
                released = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        check_int("full_releases", 32'(released), 32'd1);

        for (int k = 0; k < 100; k++) begin
            @(negedge sys_clk);
            if (!busy && sb.size() == 0) break;
        end
        check_int("drain_scoreboard_empty", 32'(sb.size()), 32'd0);
        check_obs("drain_final_state", dut_state(), model);

        // Reset while the MAC is in its accumulate cycle.
        v = mkv(4'd0, 8'hC1, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4, model);
        push(v);
        @(negedge sys_clk);
        check_int("no_done_in_exec", 32'(done), 32'd0);
        @(negedge sys_clk);
        check_int("no_done_in_mac2", 32'(done), 32'd0);
        rst = 1'b1;
        sb.delete();
        model = '0;
        @(negedge sys_clk);
        check_obs("reset_mid_mac_state", dut_state(), '0);
        check_int("reset_mid_mac_done", 32'(done), 32'd0);
        check_int("reset_mid_mac_ready", 32'(cmd_ready), 32'd1);
        check_int("reset_mid_mac_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge sys_clk);
        check_int("idle_after_reset_busy", 32'(busy), 32'd0);

        // Operation resumes after reset.
        v = mkv(4'd5, 8'h5A, 8'hC2, 32'hDEADBEEF, 8'hE1, 8'hE2, 8'hE3, 8'hE4,
                st(8'h5A, 8'h00, 32'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        push(v);
        wait_done(cyc);
        repeat (2) @(negedge sys_clk);
        check_int("final_scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
